// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditioning stage between the raw board push-button pins and the button
// controller. Every channel is synchronised into clk with a two-flop
// synchroniser. A new level is accepted only after it has been stable for
// DEBOUNCE_CYCLES consecutive cycles. Channels are identical and independent.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   raw_buttons  asynchronous button pins (pressed level set by RAW_ACTIVE_LOW)
//   buttons      debounced level, 1 = pressed
//   pressed      one-cycle pulse per accepted press (plus auto-repeats)
//   released     one-cycle pulse per accepted release
//
// Optional feature macro: BUTTON_DEBOUNCE_REPEAT_EN
//   When defined, a held button produces extra pressed pulses. The first comes
//   REPEAT_DELAY cycles after the press, then one every REPEAT_PERIOD cycles.
//   When undefined, REPEAT_DELAY/REPEAT_PERIOD have no effect.
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int N_BUTTONS       = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int RAW_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] raw_buttons,
  output logic [N_BUTTONS-1:0] buttons,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] released
);

  // Raw level that means "not pressed". The synchroniser resets to it, so the
  // first cycle after reset never looks like an edge.
  localparam logic             RAW_IDLE = (RAW_ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int               RMAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RW        = $clog2(RMAX + 1);
  localparam logic [RW-1:0]    RDLY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]    RPER_MAX  = RW'(REPEAT_PERIOD - 1);
`else
  // Repeat timing is not used in this build.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_BUTTONS; gi++) begin : g_chan
      logic             sync1_reg;
      logic             sync2_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             buttons_reg;
      logic             pressed_reg;
      logic             released_reg;
      logic             sample;
      logic             flip;
      logic             repeat_fire;

      // Normalised sample: 1 = pressed regardless of pin polarity.
      assign sample = sync2_reg ^ RAW_IDLE;
      // The stable level changes on this edge.
      assign flip   = (sample != buttons_reg) && (cnt_reg == CNT_MAX);

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      logic [RW-1:0] rcnt_reg;
      logic          rphase_reg;   // 0: waiting for first repeat, 1: periodic

      // A held button repeats, except on the edge where it is released.
      assign repeat_fire = buttons_reg && !flip &&
                           (rcnt_reg == (rphase_reg ? RPER_MAX : RDLY_MAX));

      always_ff @(posedge clk) begin
        if (rst) begin
          rcnt_reg   <= '0;
          rphase_reg <= 1'b0;
        end else if (!buttons_reg || flip) begin
          // Covers idle, the press edge and the release edge.
          rcnt_reg   <= '0;
          rphase_reg <= 1'b0;
        end else if (repeat_fire) begin
          rcnt_reg   <= '0;
          rphase_reg <= 1'b1;
        end else begin
          rcnt_reg   <= rcnt_reg + RW'(1);
        end
      end
`else
      assign repeat_fire = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg    <= RAW_IDLE;
          sync2_reg    <= RAW_IDLE;
          cnt_reg      <= '0;
          buttons_reg  <= 1'b0;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
        end else begin
          sync1_reg    <= raw_buttons[gi];
          sync2_reg    <= sync1_reg;
          pressed_reg  <= (flip && sample) || repeat_fire;
          released_reg <= flip && !sample;
          // Any sample equal to the stable level restarts the count, so a
          // single-cycle glitch back to the old level costs a full window.
          if (sample == buttons_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            buttons_reg <= sample;
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign buttons[gi]  = buttons_reg;
      assign pressed[gi]  = pressed_reg;
      assign released[gi] = released_reg;
    end
  endgenerate

endmodule
